// File: rtl/instruction_loader.sv
// Writer side of the MiniAlu instruction-fetch path: parses HEADER/count/words/checksum
// frames, writes 28-bit words to instruction memory from address 0 and gates the CPU reset.
module instruction_loader #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         ADDR_WIDTH  = 16,
   parameter int         INSTR_WIDTH = 28,
   parameter int         MAX_WORDS   = 255
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [7:0]             iByte,
   input  logic                   iByteValid,
   output logic                   oByteReady,
   output logic                   oWriteEnable,
   output logic [ADDR_WIDTH-1:0]  oWriteAddress,
   output logic [INSTR_WIDTH-1:0] oWriteData,
   output logic                   oCpuReset,
   output logic                   oDone,
   output logic                   oError
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      BYTE,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              checksum_q, checksum_d;
   logic [7:0]              wordCount_q, wordCount_d;
   logic [1:0]              byteIndex_q, byteIndex_d;
   logic [INSTR_WIDTH-9:0]  shift_q, shift_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [INSTR_WIDTH-1:0]  data_q, data_d;
   logic                    cpuReset_q, cpuReset_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    accept;

   assign oByteReady    = (state_q != WRITE);
   assign oWriteEnable  = (state_q == WRITE);
   assign oWriteAddress = addr_q;
   assign oWriteData    = data_q;
   assign oCpuReset     = cpuReset_q;
   assign oDone         = done_q;
   assign oError        = error_q;
   assign accept        = iByteValid && oByteReady;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         checksum_q  <= '0;
         wordCount_q <= '0;
         byteIndex_q <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         cpuReset_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         checksum_q  <= checksum_d;
         wordCount_q <= wordCount_d;
         byteIndex_q <= byteIndex_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cpuReset_q  <= cpuReset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      checksum_d  = checksum_q;
      wordCount_d = wordCount_q;
      byteIndex_d = byteIndex_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cpuReset_d  = cpuReset_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         COUNT: begin
            if (accept) begin
               checksum_d = iByte;
               if (iByte == 8'd0) begin
                  state_d = CHECK;
               end else if (int'(iByte) > MAX_WORDS) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else begin
                  wordCount_d = iByte;
                  byteIndex_d = 2'd0;
                  state_d     = BYTE;
               end
            end
         end
         BYTE: begin
            if (accept) begin
               checksum_d = checksum_q + iByte;
               shift_d    = {shift_q[INSTR_WIDTH-17:0], iByte};
               // The top nibble of each word's first byte lies beyond the 28-bit instruction.
               if (byteIndex_q == 2'd0 && iByte[7:4] != 4'd0) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else if (byteIndex_q == 2'd3) begin
                  data_d      = {shift_q, iByte};
                  byteIndex_d = 2'd0;
                  state_d     = WRITE;
               end else begin
                  byteIndex_d = byteIndex_q + 2'd1;
               end
            end
         end
         WRITE: begin
            addr_d      = addr_q + 1'b1;
            wordCount_d = wordCount_q - 8'd1;
            state_d     = (wordCount_q == 8'd1) ? CHECK : BYTE;
         end
         CHECK: begin
            if (accept) begin
               if (iByte == checksum_q) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpuReset_d = 1'b0;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end
         end
         default: begin
            // IDLE, DONE and ERROR all restart on a header and ignore everything else.
            if (accept && iByte == HEADER) begin
               state_d    = COUNT;
               checksum_d = '0;
               addr_d     = '0;
               done_d     = 1'b0;
               error_d    = 1'b0;
               cpuReset_d = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed-frame bench for instruction_loader: expected writes go into a scoreboard queue
// that a negedge monitor drains whenever the write strobe is seen.
module tb_instruction_loader;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [7:0]  iByte;
   logic        iByteValid;
   logic        oByteReady;
   logic        oWriteEnable;
   logic [15:0] oWriteAddress;
   logic [27:0] oWriteData;
   logic        oCpuReset;
   logic        oDone;
   logic        oError;

   typedef struct packed {
      logic [15:0] addr;
      logic [27:0] data;
   } write_t;

   write_t     expQ[$];
   write_t     expWr;
   logic [7:0] stimQ[$];
   int         compared = 0;
   int         mismatched = 0;
   int         readyLowCount = 0;
   logic       countReady = 1'b0;

   instruction_loader dut (
      .Clock(Clock),
      .Reset(Reset),
      .iByte(iByte),
      .iByteValid(iByteValid),
      .oByteReady(oByteReady),
      .oWriteEnable(oWriteEnable),
      .oWriteAddress(oWriteAddress),
      .oWriteData(oWriteData),
      .oCpuReset(oCpuReset),
      .oDone(oDone),
      .oError(oError)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present one byte and hold it until the loader takes it; returns 1 time unit after that edge.
   task automatic applyStimulus(input logic [7:0] b);
      int waitCycles;
      waitCycles = 0;
      iByte      = b;
      iByteValid = 1'b1;
      while (oByteReady !== 1'b1 && waitCycles < 8) begin
         @(negedge Clock);
         waitCycles++;
      end
      if (oByteReady !== 1'b1) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL ready_timeout: byte %0h never accepted, expected ready within 8 cycles", b);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic sendQueue();
      foreach (stimQ[i]) applyStimulus(stimQ[i]);
      iByteValid = 1'b0;
   endtask

   task automatic pushWrite(input logic [15:0] addr, input logic [27:0] data);
      expQ.push_back('{addr: addr, data: data});
   endtask

   always @(negedge Clock) begin
      if (countReady && oByteReady === 1'b0) readyLowCount++;
      if (oWriteEnable === 1'b1) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", oWriteAddress, oWriteData);
         end else begin
            expWr = expQ.pop_front();
            checkOutput("write_addr", 32'(oWriteAddress), 32'(expWr.addr));
            checkOutput("write_data", 32'(oWriteData), 32'(expWr.data));
            checkOutput("ready_in_write", 32'(oByteReady), 32'd0);
         end
      end
   end

   initial begin
      Reset      = 1'b0;
      iByte      = 8'h00;
      iByteValid = 1'b0;
      repeat (3) @(negedge Clock);
      checkOutput("reset_we", 32'(oWriteEnable), 32'd0);
      checkOutput("reset_addr", 32'(oWriteAddress), 32'd0);
      checkOutput("reset_data", 32'(oWriteData), 32'd0);
      checkOutput("reset_cpu", 32'(oCpuReset), 32'd1);
      checkOutput("reset_done", 32'(oDone), 32'd0);
      checkOutput("reset_error", 32'(oError), 32'd0);
      checkOutput("reset_ready", 32'(oByteReady), 32'd1);
      Reset = 1'b1;
      @(negedge Clock);

      $display("[TB] two-word frame, good checksum");
      pushWrite(16'd0, 28'h1020304);
      pushWrite(16'd1, 28'h5060708);
      stimQ = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      sendQueue();
      checkOutput("f1_cpu_before_cs", 32'(oCpuReset), 32'd1);
      checkOutput("f1_done_before_cs", 32'(oDone), 32'd0);
      applyStimulus(8'h26);
      iByteValid = 1'b0;
      checkOutput("f1_cpu", 32'(oCpuReset), 32'd0);
      checkOutput("f1_done", 32'(oDone), 32'd1);
      checkOutput("f1_error", 32'(oError), 32'd0);

      $display("[TB] same frame, bad checksum");
      pushWrite(16'd0, 28'h1020304);
      pushWrite(16'd1, 28'h5060708);
      applyStimulus(8'hA5);
      checkOutput("f2_cpu_rearmed", 32'(oCpuReset), 32'd1);
      checkOutput("f2_done_cleared", 32'(oDone), 32'd0);
      stimQ = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h27};
      sendQueue();
      checkOutput("f2_error", 32'(oError), 32'd1);
      checkOutput("f2_cpu", 32'(oCpuReset), 32'd1);
      checkOutput("f2_done", 32'(oDone), 32'd0);

      $display("[TB] recovery frame after error");
      pushWrite(16'd0, 28'h1020304);
      pushWrite(16'd1, 28'h5060708);
      applyStimulus(8'hA5);
      checkOutput("f3_error_cleared", 32'(oError), 32'd0);
      stimQ = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
      sendQueue();
      checkOutput("f3_done", 32'(oDone), 32'd1);
      checkOutput("f3_cpu", 32'(oCpuReset), 32'd0);

      $display("[TB] bad top nibble in first word byte");
      stimQ = '{8'hA5, 8'h01, 8'hF0};
      sendQueue();
      checkOutput("nib_error", 32'(oError), 32'd1);
      checkOutput("nib_cpu", 32'(oCpuReset), 32'd1);
      stimQ = '{8'h00, 8'h00, 8'h00};
      sendQueue();
      checkOutput("nib_error_held", 32'(oError), 32'd1);
      checkOutput("nib_done", 32'(oDone), 32'd0);

      $display("[TB] garbage then empty frame from idle");
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      stimQ = '{8'h00, 8'hFF, 8'h13};
      sendQueue();
      checkOutput("garbage_done", 32'(oDone), 32'd0);
      stimQ = '{8'hA5, 8'h00, 8'h00};
      sendQueue();
      checkOutput("empty_done", 32'(oDone), 32'd1);
      checkOutput("empty_cpu", 32'(oCpuReset), 32'd0);
      checkOutput("empty_error", 32'(oError), 32'd0);

      $display("[TB] three-word frame with continuous valid");
      pushWrite(16'd0, 28'hABCDEF1);
      pushWrite(16'd1, 28'h1234567);
      pushWrite(16'd2, 28'hFFFFFFF);
      countReady = 1'b1;
      stimQ = '{8'hA5, 8'h03, 8'h0A, 8'hBC, 8'hDE, 8'hF1, 8'h01, 8'h23, 8'h45, 8'h67,
                8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h74};
      sendQueue();
      countReady = 1'b0;
      checkOutput("stream_ready_low_cycles", 32'(readyLowCount), 32'd3);
      checkOutput("stream_done", 32'(oDone), 32'd1);

      $display("[TB] reset during second word");
      pushWrite(16'd0, 28'h1020304);
      stimQ = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      sendQueue();
      checkOutput("mid_addr_advanced", 32'(oWriteAddress), 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      checkOutput("mid_we", 32'(oWriteEnable), 32'd0);
      checkOutput("mid_addr", 32'(oWriteAddress), 32'd0);
      checkOutput("mid_data", 32'(oWriteData), 32'd0);
      checkOutput("mid_cpu", 32'(oCpuReset), 32'd1);
      checkOutput("mid_done", 32'(oDone), 32'd0);
      checkOutput("mid_error", 32'(oError), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      pushWrite(16'd0, 28'h1020304);
      pushWrite(16'd1, 28'h5060708);
      stimQ = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
      sendQueue();
      checkOutput("post_reset_done", 32'(oDone), 32'd1);
      checkOutput("post_reset_cpu", 32'(oCpuReset), 32'd0);

      repeat (4) @(negedge Clock);
      checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the MiniAlu instruction-fetch path: receives a framed byte stream, assembles 28-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the processor in reset (active-high) until a complete frame with a valid checksum has been written.
- Sits between a byte source (UART receiver or debug port) and the instruction memory write port / MiniAlu Reset.

Parameters:
HEADER, 8'hA5, frame start byte
ADDR_WIDTH, 16, write address width (matches IP width)
INSTR_WIDTH, 28, instruction word width
MAX_WORDS, 255, largest accepted instruction count (1..255)

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
iByte  input  8  incoming stream byte
iByteValid  input  1  iByte valid this cycle
oByteReady  output  1  loader accepts a byte this cycle
oWriteEnable  output  1  one-cycle instruction memory write strobe
oWriteAddress  output  ADDR_WIDTH  write address
oWriteData  output  INSTR_WIDTH  instruction word
oCpuReset  output  1  active-high reset to processor
oDone  output  1  last frame loaded successfully
oError  output  1  last frame rejected

Behaviour:
- Byte transfer occurs only on a rising Clock edge with iByteValid=1 and oByteReady=1; other bytes are ignored.
- Reset low (asynchronous): state IDLE; oWriteEnable=0, oWriteAddress=0, oWriteData=0, oCpuReset=1, oDone=0, oError=0, checksum accumulator=0, word counter=0, byte index=0.
- Reset asserted mid-frame aborts the frame immediately. Memory already written is left as is. The CPU stays in reset.
- oByteReady = 1 in every state except WRITE. It is a combinational decode of the state.
- Frame format: HEADER, count N, 4*N instruction bytes (MSB first, 4 bytes per word), checksum byte.
- Checksum rule: 8-bit sum mod 256 of the count byte and all instruction bytes.
- States:
  - IDLE: accepted byte == HEADER -> COUNT. Any other byte is discarded.
  - COUNT:
    - Clear checksum and oWriteAddress.
    - Deassert oDone and oError; assert oCpuReset.
    - N==0 -> CHECK. N>MAX_WORDS -> ERROR. Otherwise load word counter=N, byte index=0 -> BYTE.
  - BYTE:
    - Shift the accepted byte into the word register and add it to the checksum.
    - Byte index 0: bits [7:4] must be 0, otherwise -> ERROR.
    - After index 3 is accepted -> WRITE.
  - WRITE:
    - Exactly one cycle. oWriteEnable=1; oWriteData = assembled word[27:0]; oWriteAddress = current address.
    - Next cycle: address+1, counter-1. Counter reaches 0 -> CHECK, else -> BYTE.
    - No byte is accepted in this cycle.
  - CHECK: accepted byte == checksum -> DONE, else -> ERROR.
  - DONE: oCpuReset=0 and oDone=1, both registered, from the first cycle in DONE. A HEADER byte -> COUNT (reload, CPU reset re-asserted next cycle). Other bytes are ignored.
  - ERROR: oError=1, oCpuReset=1. A HEADER byte -> COUNT. Other bytes are ignored.
- oWriteEnable is 0 in all states except WRITE. oWriteAddress holds its last value outside WRITE.
- Address never wraps, because N ≤ MAX_WORDS < 2^ADDR_WIDTH.
- Latency: the 4th byte of a word is accepted at edge k; the write strobe is high during cycle k+1.
- A stalled source (iByteValid=0) may pause any receive state indefinitely, with no timeout.

Test Plan:
- Reset released, stream A5 02 01 02 03 04 05 06 07 08 26:
  - Write strobes at addr 0 data 28'h1020304, then addr 1 data 28'h5060708.
  - oCpuReset falls and oDone=1 one cycle after the checksum byte.
- Same frame with checksum 27: both writes occur, oError=1, oCpuReset stays 1, oDone=0. A following correct frame clears oError and reaches DONE.
- Stream A5 01 F0 00 00 00: ERROR right after byte F0. No write strobe. The remaining 3 bytes are ignored.
- Garbage 00 FF 13, then A5 00 00: garbage discarded. DONE with no writes. oCpuReset=0.
- iByteValid held high continuously during a 3-word frame: oByteReady=0 exactly in each WRITE cycle. No byte is lost or duplicated (check the addresses 0,1,2 and their data).
- Reset pulled low during the second word of a frame: all outputs return to reset values asynchronously. A subsequent full frame loads correctly from address 0.
